// File: rtl/cmp_disp_pkg.sv
// Shared constants for the scanned compare-result display.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cmp_disp_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;

  // One-hot compare codes {greater, equal, less}
  localparam logic [2:0] GEL_GT = 3'b100;
  localparam logic [2:0] GEL_EQ = 3'b010;
  localparam logic [2:0] GEL_LT = 3'b001;

  // Digit positions on the eight-digit strip
  typedef logic [2:0] dig_idx_t;
  localparam dig_idx_t DIG_A_HI = 3'd7;
  localparam dig_idx_t DIG_A_LO = 3'd6;
  localparam dig_idx_t DIG_B_HI = 3'd3;
  localparam dig_idx_t DIG_B_LO = 3'd2;
  localparam dig_idx_t DIG_SYM  = 3'd0;

endpackage

// File: rtl/cmp_scan_display_if.sv
// Bundle of capture inputs and display pins.
// Latency: n/a (wiring only).
// Backpressure: none; load is a plain strobe.
interface cmp_scan_display_if;
  logic       load;
  logic [6:0] a;
  logic [6:0] b;
  logic [2:0] gel;
  logic [7:0] anode;
  logic [6:0] seg;
  logic       dp;

  modport master (output load, a, b, gel, input anode, seg, dp);
  modport slave  (input load, a, b, gel, output anode, seg, dp);
endinterface

// File: rtl/cmp_scan_display_hex_to_seg.sv
// Combinational 4-bit hex digit to active-low 7-segment pattern.
// Latency: 0 cycles (pure logic).
// Backpressure: none.
module hex_to_seg (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Lookup table, {g,f,e,d,c,b,a} active-low
  always_comb begin
    o_seg = 7'b1111111;
    case (i_nib)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/cmp_scan_display.sv
// Scanned eight-digit driver showing a, b in hex and the G/E/L compare symbol.
// Latency: 1 cycle from digit index or captured data to anode/seg pins.
// Backpressure: none; every load strobe is captured, last one wins.
module cmp_scan_display
  import cmp_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  cmp_scan_display_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] r_pre;
  dig_idx_t      r_idx;
  logic [BW-1:0] r_blk;
  logic          r_phase;
  logic [6:0]    r_a;
  logic [6:0]    r_b;
  logic [2:0]    r_gel;
  logic [7:0]    r_anode;
  logic [6:0]    r_seg;

  logic [3:0]    w_nib;
  logic [6:0]    w_hex;
  logic [6:0]    w_sym;
  logic [6:0]    w_seg_nxt;

  // Digit dwell prescaler; advances the scan index on terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_LAST) begin
      r_pre <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Free-running blink timebase; phase flips each half-period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk   <= '0;
      r_phase <= 1'b0;
    end else if (r_blk == BLK_LAST) begin
      r_blk   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_blk <= r_blk + BW'(1);
    end
  end

  // Operand and compare-code capture on the load strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_gel <= '0;
    end else if (bus.load) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_gel <= bus.gel;
    end
  end

  // Pick the nibble feeding the single hex decoder for the lit digit
  always_comb begin
    w_nib = 4'h0;
    case (r_idx)
      DIG_A_HI: w_nib = {1'b0, r_a[6:4]};
      DIG_A_LO: w_nib = r_a[3:0];
      DIG_B_HI: w_nib = {1'b0, r_b[6:4]};
      DIG_B_LO: w_nib = r_b[3:0];
      default:  w_nib = 4'h0;
    endcase
  end

  hex_to_seg u_hex (
    .i_nib (w_nib),
    .o_seg (w_hex)
  );

  // Compare symbol; equal blinks dark on the odd blink phase
  always_comb begin
    w_sym = SEG_DASH;
    case (r_gel)
      GEL_GT:  w_sym = SEG_G;
      GEL_EQ:  w_sym = r_phase ? SEG_BLANK : SEG_E;
      GEL_LT:  w_sym = SEG_L;
      default: w_sym = SEG_DASH;
    endcase
  end

  // Segment content for the current digit; unused positions stay blank
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    case (r_idx)
      DIG_SYM:                               w_seg_nxt = w_sym;
      DIG_A_HI, DIG_A_LO, DIG_B_HI, DIG_B_LO: w_seg_nxt = w_hex;
      default:                               w_seg_nxt = SEG_BLANK;
    endcase
  end

  // Anode and segments registered together so they switch on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anode <= 8'hFF;
      r_seg   <= SEG_BLANK;
    end else begin
      r_anode <= ~(8'd1 << r_idx);
      r_seg   <= w_seg_nxt;
    end
  end

  assign bus.anode = r_anode;
  assign bus.seg   = r_seg;
  assign bus.dp    = 1'b1;

endmodule
